ofdm_sym_sched: RTL and testbench
=================================

// Module: ofdm_sym_sched
// PURPOSE
//  Frame scheduler ahead of the CP inserter. Shares the inserter's single input
//  between two requesters: the preamble generator and the IFFT data path.
//  Per frame it forwards NPRE preamble symbols, then NSYM data symbols, each
//  SYM_LEN samples long, as ACK-qualified real/imag words.
//  It also provides symbol and frame markers to downstream framing logic.
// PARAMETERS
//  SYM_LEN  64  samples per symbol handed to the CP inserter
//  NPRE     2   preamble symbols per frame (>=1)
//  GAP_LEN  16  idle cycles between symbols (used only with GUARD_GAP_EN)
// PORTS
//  CLK_I        in   1   clock
//  RST_I        in   1   synchronous active-high reset
//  START_I      in   1   frame request (sampled in IDLE only)
//  ABORT_I      in   1   terminate frame, return to IDLE
//  NSYM_I       in   8   data symbols in frame, latched on accepted START_I
//  PRE_VLD_I    in   1   preamble word valid
//  PRE_DAT_r/i  in   16  preamble word real/imag
//  PRE_RDY_O    out  1   preamble word consumed when PRE_VLD_I & PRE_RDY_O
//  DAT_VLD_I    in   1   IFFT word valid
//  DAT_I_r/i    in   16  IFFT word real/imag
//  DAT_RDY_O    out  1   IFFT word consumed when DAT_VLD_I & DAT_RDY_O
//  ACK_O        out  1   output word valid (drives CP inserter ACK_I)
//  DAT_O_r/i    out  16  output word real/imag
//  SYM_START_O  out  1   high with first word of every symbol
//  FRM_DONE_O   out  1   one-cycle pulse after last word of frame
//  BUSY_O       out  1   high in any state other than IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters 0; latched NSYM 0.
//  FSM: IDLE -> PRE (START_I & ~ABORT_I); PRE -> DATA after NPRE symbols
//   (-> DONE if latched NSYM==0); DATA -> DONE after NSYM symbols;
//   DONE -> IDLE after one cycle, FRM_DONE_O=1 in DONE.
//  PRE_RDY_O=1 only in PRE; DAT_RDY_O=1 only in DATA; never both.
//  RDY is combinational from state; source may hold VLD low (stall): no
//   transfer, ACK_O=0 next cycle, counters hold. No timeout.
//  Latency: accepted word appears on DAT_O_r/i with ACK_O=1 one cycle later.
//   DAT_O_r/i hold last value when ACK_O=0.
//  Counters: sample cnt 0..SYM_LEN-1 wraps on last accepted word, symbol cnt
//   increments on wrap; state transition on wrap of final symbol, so the
//   last word of PRE and first word of DATA may be accepted on consecutive cycles.
//  SYM_START_O registered alongside ACK_O when sample cnt was 0 at acceptance.
//  START_I while BUSY_O: ignored; NSYM_I changes while busy: ignored.
//  ABORT_I (any state): next cycle IDLE, RDY low same cycle, ACK_O=0,
//   counters cleared, no FRM_DONE_O. ABORT_I beats START_I in IDLE.
//  RST_I mid-frame: identical to reset values, partial symbol discarded.
// CONFIGURATION
//  GUARD_GAP_EN defined: GAP state entered after every symbol wrap except the
//   last of the frame; holds both RDY low and ACK_O=0 for GAP_LEN cycles, then
//   resumes PRE or DATA. Not defined: no GAP state, symbols back-to-back,
//   GAP_LEN unused.
// TESTING
//  NSYM=3, both VLD held 1 -> 128 PRE words then 192 DATA words, ACK_O 320
//   consecutive cycles, SYM_START_O 5 pulses, FRM_DONE_O 1 cycle after last word.
//  NSYM=0 -> 128 preamble words only, DAT_RDY_O never high, FRM_DONE_O once.
//  DAT_VLD_I low every 3rd cycle -> ACK_O gaps match stalls, 64 words/symbol
//   exact, output data equals input sequence with no loss or duplication.
//  ABORT_I at DATA sample 20 -> IDLE next cycle, no FRM_DONE_O; new START
//   restarts at preamble sample 0.
//  START_I pulsed during frame with NSYM_I=9 -> ignored, frame length unchanged.
//  GUARD_GAP_EN, NSYM=1 -> exactly 16 idle cycles between symbols 1-2 and 2-3,
//   none after last; without macro -> zero gap cycles.

Source files
------------

// File: rtl/ofdm_sym_sched_if.sv
// ofdm_sym_sched_if: preamble/IFFT source handshakes and CP-inserter output bundle
interface ofdm_sym_sched_if;
    logic        PRE_VLD_I;
    logic [15:0] PRE_DAT_r;
    logic [15:0] PRE_DAT_i;
    logic        PRE_RDY_O;
    logic        DAT_VLD_I;
    logic [15:0] DAT_I_r;
    logic [15:0] DAT_I_i;
    logic        DAT_RDY_O;
    logic        ACK_O;
    logic [15:0] DAT_O_r;
    logic [15:0] DAT_O_i;
    logic        SYM_START_O;
    logic        FRM_DONE_O;
    logic        BUSY_O;

    modport slave (
        input  PRE_VLD_I, PRE_DAT_r, PRE_DAT_i, DAT_VLD_I, DAT_I_r, DAT_I_i,
        output PRE_RDY_O, DAT_RDY_O, ACK_O, DAT_O_r, DAT_O_i, SYM_START_O, FRM_DONE_O, BUSY_O
    );

    modport master (
        output PRE_VLD_I, PRE_DAT_r, PRE_DAT_i, DAT_VLD_I, DAT_I_r, DAT_I_i,
        input  PRE_RDY_O, DAT_RDY_O, ACK_O, DAT_O_r, DAT_O_i, SYM_START_O, FRM_DONE_O, BUSY_O
    );
endinterface

// File: rtl/ofdm_sym_sched.sv
// ofdm_sym_sched: forwards NPRE preamble then NSYM IFFT symbols to the CP inserter; GUARD_GAP_EN adds GAP_LEN idle cycles between symbols
module ofdm_sym_sched #(
    parameter int SYM_LEN = 64,
    parameter int NPRE    = 2,
    parameter int GAP_LEN = 16
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       START_I,
    input  logic       ABORT_I,
    input  logic [7:0] NSYM_I,
    ofdm_sym_sched_if.slave bus
);
    localparam int CW = $clog2(SYM_LEN);
    typedef enum logic [2:0] {IDLE, PRE, DATA, GAP, DONE} state_t;
    state_t state, state_d, after_sym;
    logic [CW-1:0] smp_cnt;
    logic [7:0] sym_cnt, nsym_q;
    logic xfer, wrap, last_sym;

    assign bus.PRE_RDY_O  = (state == PRE) && !ABORT_I;
    assign bus.DAT_RDY_O  = (state == DATA) && !ABORT_I;
    assign bus.FRM_DONE_O = state == DONE;
    assign bus.BUSY_O     = state != IDLE;
    assign xfer     = (bus.PRE_RDY_O && bus.PRE_VLD_I) || (bus.DAT_RDY_O && bus.DAT_VLD_I);
    assign wrap     = xfer && smp_cnt == CW'(SYM_LEN - 1);
    assign last_sym = (state == PRE) ? sym_cnt == 8'(NPRE - 1) : sym_cnt == nsym_q - 8'd1;
    assign after_sym = !last_sym ? state : (state == PRE && nsym_q != 8'd0) ? DATA : DONE;

`ifdef GUARD_GAP_EN
    localparam int GW = $clog2(GAP_LEN + 1);
    logic [GW-1:0] gap_cnt;
    state_t ret_q;

    // gap length counter and the symbol state to resume afterwards
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            gap_cnt <= '0;
            ret_q   <= IDLE;
        end else begin
            gap_cnt <= (state == GAP && !ABORT_I) ? gap_cnt + 1'b1 : '0;
            if (wrap) ret_q <= after_sym;
        end
    end
`else
    logic unused_gap;
    assign unused_gap = GAP_LEN != 0;
`endif

    // state register
    always_ff @(posedge CLK_I) begin
        if (RST_I) state <= IDLE;
        else state <= state_d;
    end

    // next state: abort wins, symbol wraps advance the frame
    always_comb begin
        state_d = state;
        if (ABORT_I) state_d = IDLE;
        else if (state == IDLE && START_I) state_d = PRE;
`ifdef GUARD_GAP_EN
        else if (wrap) state_d = (after_sym == DONE) ? DONE : GAP;
        else if (state == GAP && gap_cnt == GW'(GAP_LEN - 1)) state_d = ret_q;
`else
        else if (wrap) state_d = after_sym;
`endif
        else if (state == DONE) state_d = IDLE;
    end

    // sample/symbol counters, NSYM latch and one-cycle-delayed output word
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            smp_cnt         <= '0;
            sym_cnt         <= '0;
            nsym_q          <= '0;
            bus.ACK_O       <= 1'b0;
            bus.SYM_START_O <= 1'b0;
            bus.DAT_O_r     <= '0;
            bus.DAT_O_i     <= '0;
        end else begin
            bus.ACK_O       <= xfer;
            bus.SYM_START_O <= xfer && smp_cnt == '0;
            if (xfer) begin
                bus.DAT_O_r <= (state == PRE) ? bus.PRE_DAT_r : bus.DAT_I_r;
                bus.DAT_O_i <= (state == PRE) ? bus.PRE_DAT_i : bus.DAT_I_i;
            end
            if (state == IDLE && START_I && !ABORT_I) nsym_q <= NSYM_I;
            if (ABORT_I) begin
                smp_cnt <= '0;
                sym_cnt <= '0;
            end else if (xfer) begin
                smp_cnt <= wrap ? '0 : smp_cnt + 1'b1;
                if (wrap) sym_cnt <= last_sym ? 8'd0 : sym_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_ofdm_sym_sched.sv
// tb_ofdm_sym_sched: directed frame tests for ofdm_sym_sched
`timescale 1ns/1ps
module tb_ofdm_sym_sched;
    localparam int NPRE = 2;
`ifdef GUARD_GAP_EN
    localparam int GAPC = 16;
`else
    localparam int GAPC = 0;
`endif
    logic CLK_I = 0, RST_I = 1, START_I = 0, ABORT_I = 0;
    logic [7:0] NSYM_I = 0;
    logic pre_en = 0, dat_en = 0, stall_mode = 0, clr = 0;
    logic [15:0] pre_idx = 0, dat_idx = 0, exp_w;
    int cyc = 0, stall_cnt = 0;
    int k = 0, ack_cnt = 0, ss_cnt = 0, fd_cnt = 0, rdy_seen = 0, ack_low = 0;
    int seq_err = 0, ss_err = 0, fd_err = 0, in_frm = 0;
    int checks = 0, failures = 0;

    ofdm_sym_sched_if bus();

    ofdm_sym_sched dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .START_I(START_I), .ABORT_I(ABORT_I),
        .NSYM_I(NSYM_I), .bus(bus)
    );

    always #5 CLK_I = ~CLK_I;

    assign bus.PRE_VLD_I = pre_en;
    assign bus.PRE_DAT_r = 16'h1000 + pre_idx;
    assign bus.PRE_DAT_i = ~(16'h1000 + pre_idx);
    assign bus.DAT_VLD_I = dat_en && !(stall_mode && cyc % 3 == 0);
    assign bus.DAT_I_r   = 16'h2000 + dat_idx;
    assign bus.DAT_I_i   = ~(16'h2000 + dat_idx);

    always @(negedge CLK_I) cyc <= cyc + 1;

    // sources advance their word index on every accepted transfer
    always @(posedge CLK_I) begin
        if (clr) begin
            pre_idx   <= 0;
            dat_idx   <= 0;
            stall_cnt <= 0;
        end else begin
            if (bus.PRE_VLD_I && bus.PRE_RDY_O) pre_idx <= pre_idx + 1;
            if (bus.DAT_VLD_I && bus.DAT_RDY_O) dat_idx <= dat_idx + 1;
            if (bus.DAT_RDY_O && !bus.DAT_VLD_I) stall_cnt <= stall_cnt + 1;
        end
    end

    // output monitor: expected stream is preamble 0x1000.. then data 0x2000..
    always @(posedge CLK_I) begin
        #1;
        if (clr) begin
            k = 0; ack_cnt = 0; ss_cnt = 0; fd_cnt = 0; rdy_seen = 0; ack_low = 0;
            seq_err = 0; ss_err = 0; fd_err = 0; in_frm = 0;
        end else begin
            if (bus.ACK_O) begin
                exp_w = (k < NPRE * 64) ? 16'h1000 + 16'(k) : 16'h2000 + 16'(k - NPRE * 64);
                if (bus.DAT_O_r != exp_w || bus.DAT_O_i != ~exp_w) seq_err++;
                if (bus.SYM_START_O != (k % 64 == 0)) ss_err++;
                k++;
                ack_cnt++;
                in_frm = 1;
            end else begin
                if (bus.SYM_START_O) ss_err++;
                if (in_frm != 0 && !bus.FRM_DONE_O) ack_low++;
            end
            if (bus.SYM_START_O) ss_cnt++;
            if (bus.DAT_RDY_O) rdy_seen++;
            if (bus.FRM_DONE_O) begin
                fd_cnt++;
                in_frm = 0;
                if (!bus.ACK_O) fd_err++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] n);
        @(negedge CLK_I);
        clr = 1;
        @(negedge CLK_I);
        clr = 0; pre_en = 1; dat_en = 1; NSYM_I = n; START_I = 1;
        @(negedge CLK_I);
        START_I = 0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000 && bus.BUSY_O; i++) @(negedge CLK_I);
        check({tag, "_idle"}, {31'd0, bus.BUSY_O}, 0);
        @(negedge CLK_I);
    endtask

    initial begin
        repeat (3) @(negedge CLK_I);
        check("rst_ack", {31'd0, bus.ACK_O}, 0);
        check("rst_busy", {31'd0, bus.BUSY_O}, 0);
        check("rst_rdy", {30'd0, bus.PRE_RDY_O, bus.DAT_RDY_O}, 0);
        check("rst_dat", {bus.DAT_O_r, bus.DAT_O_i}, 0);
        check("rst_flags", {30'd0, bus.SYM_START_O, bus.FRM_DONE_O}, 0);
        RST_I = 0;

        start_frame(3);
        check("f3_busy", {31'd0, bus.BUSY_O}, 1);
        wait_idle("f3");
        check("f3_acks", ack_cnt, 320);
        check("f3_sym_starts", ss_cnt, 5);
        check("f3_ss_pos", ss_err, 0);
        check("f3_seq", seq_err, 0);
        check("f3_frm_done", fd_cnt, 1);
        check("f3_fd_align", fd_err, 0);
        check("f3_gap_cycles", ack_low, GAPC * 4);
        check("f3_hold", bus.DAT_O_r, 16'h20BF);

        start_frame(0);
        wait_idle("f0");
        check("f0_acks", ack_cnt, 128);
        check("f0_dat_rdy", rdy_seen, 0);
        check("f0_frm_done", fd_cnt, 1);
        check("f0_sym_starts", ss_cnt, 2);

        stall_mode = 1;
        start_frame(2);
        wait_idle("stall");
        stall_mode = 0;
        check("stall_acks", ack_cnt, 256);
        check("stall_seq", seq_err, 0);
        check("stall_ss_pos", ss_err, 0);
        check("stall_seen", {31'd0, stall_cnt > 0}, 1);
        check("stall_gaps", ack_low, stall_cnt + GAPC * 3);

        start_frame(3);
        for (int i = 0; i < 2000 && dat_idx != 20; i++) @(negedge CLK_I);
        check("ab_reach", dat_idx, 20);
        ABORT_I = 1;
        #1;
        check("ab_rdy_low", {30'd0, bus.PRE_RDY_O, bus.DAT_RDY_O}, 0);
        @(negedge CLK_I);
        ABORT_I = 0;
        check("ab_idle", {31'd0, bus.BUSY_O}, 0);
        check("ab_ack", {31'd0, bus.ACK_O}, 0);
        check("ab_acks", ack_cnt, 148);
        repeat (2) @(negedge CLK_I);
        check("ab_no_done", fd_cnt, 0);
        start_frame(0);
        wait_idle("ab_re");
        check("ab_re_acks", ack_cnt, 128);
        check("ab_re_ss", ss_cnt, 2);
        check("ab_re_ss_pos", ss_err, 0);

        start_frame(2);
        repeat (50) @(negedge CLK_I);
        START_I = 1; NSYM_I = 9;
        @(negedge CLK_I);
        START_I = 0;
        wait_idle("dup");
        check("dup_acks", ack_cnt, 256);
        check("dup_ss", ss_cnt, 4);
        check("dup_done", fd_cnt, 1);

        start_frame(1);
        wait_idle("g1");
        check("g1_acks", ack_cnt, 192);
        check("g1_gap_cycles", ack_low, GAPC * 2);
        check("g1_seq", seq_err, 0);

        @(negedge CLK_I);
        START_I = 1; ABORT_I = 1;
        @(negedge CLK_I);
        START_I = 0; ABORT_I = 0;
        check("abort_beats_start", {31'd0, bus.BUSY_O}, 0);

        start_frame(3);
        repeat (30) @(negedge CLK_I);
        RST_I = 1;
        @(negedge CLK_I);
        check("mrst_busy", {31'd0, bus.BUSY_O}, 0);
        check("mrst_ack", {30'd0, bus.ACK_O, bus.SYM_START_O}, 0);
        check("mrst_dat", {bus.DAT_O_r, bus.DAT_O_i}, 0);
        RST_I = 0;
        start_frame(0);
        wait_idle("mrst_re");
        check("mrst_re_acks", ack_cnt, 128);
        check("mrst_re_ss_pos", ss_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
